// File: rtl/keypad_pkg.sv
// Shared sizing helpers, serializer state type and event layout for the keypad scanner.
// HEX_MAP_4X4 is the printed legend of the standard 4x4 pad, indexed by raw key index.
package keypad_pkg;

  typedef enum logic {SER_IDLE, SER_RUN} ser_state_e;

  function automatic int key_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Release flag sits just above the key index in an event word.
  function automatic int rel_bit(input int rows, input int cols);
    return key_w(rows, cols);
  endfunction

  localparam logic [3:0] HEX_MAP_4X4 [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

endpackage

// File: rtl/key_debounce.sv
// One key's debouncer: stable flips after DEBOUNCE consecutive differing samples.
// change_o pulses combinationally during the sampling cycle that causes the flip.
module key_debounce #(
  parameter int DEBOUNCE = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en_i,
  input  logic sample_i,
  output logic stable_o,
  output logic change_o
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          differ;

  assign differ = sample_i ^ stable_q;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    change_o = 1'b0;
    if (sample_en_i) begin
      if (!differ) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
        change_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: row strobing, per-key debounce, press/release events via a ready/valid FIFO.
// Events reach ev_valid COLS+3 clocks max after the flipping tick; a full FIFO without a pop drops and sets overflow.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 32768,
  parameter int DEBOUNCE   = 12,
  parameter int FIFO_DEPTH = 8,
  localparam int KEY_W     = key_w(ROWS, COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ROWS-1:0]      rowwrite,
  input  logic [COLS-1:0]      colread,
  output logic [KEY_W:0]       ev_data,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [ROWS*COLS-1:0] pressed_map,
  output logic                 any_pressed,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  localparam int NK  = ROWS * COLS;
  localparam int REL = rel_bit(ROWS, COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = KEY_W + 1;

  logic [COLS-1:0]  col_s1_q, col_s2_q;
  logic [DW-1:0]    div_cnt_q;
  logic [RW-1:0]    row_q;
  logic [ROWS-1:0]  rowwrite_q;
  logic             tick;

  logic [NK-1:0]    stable, change;
  logic [NK-1:0]    flag_q, flag_d;

  ser_state_e       ser_q;
  logic [RW-1:0]    ser_row_q;
  logic [CW-1:0]    ser_col_q;
  logic [KEY_W-1:0] ser_idx;
  logic             push_q;
  logic [EW-1:0]    push_dat_q;

  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, pop, wr_en, drop;
  logic             overflow_q;

  assign tick = (div_cnt_q == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1_q   <= '1;
      col_s2_q   <= '1;
      div_cnt_q  <= '0;
      row_q      <= '0;
      rowwrite_q <= {{(ROWS-1){1'b1}}, 1'b0};
    end else begin
      col_s1_q <= colread;
      col_s2_q <= col_s1_q;
      if (tick) begin
        div_cnt_q  <= '0;
        row_q      <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        rowwrite_q <= {rowwrite_q[ROWS-2:0], rowwrite_q[ROWS-1]};
      end else begin
        div_cnt_q <= div_cnt_q + DW'(1);
      end
    end
  end

  // Only the active row's keys see a sample, once per frame.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key (
        .clk         (clk),
        .rst         (rst),
        .sample_en_i (tick && (row_q == RW'(r))),
        .sample_i    (~col_s2_q[c]),
        .stable_o    (stable[r*COLS+c]),
        .change_o    (change[r*COLS+c])
      );
    end
  end

  assign ser_idx = KEY_W'(ser_row_q) * KEY_W'(COLS) + KEY_W'(ser_col_q);

  always_comb begin
    flag_d = flag_q | change;
    if (ser_q == SER_RUN) flag_d[ser_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ser_q      <= SER_IDLE;
      ser_row_q  <= '0;
      ser_col_q  <= '0;
      flag_q     <= '0;
      push_q     <= 1'b0;
      push_dat_q <= '0;
    end else begin
      flag_q <= flag_d;
      push_q <= 1'b0;
      case (ser_q)
        SER_IDLE: begin
          if (tick) begin
            ser_q     <= SER_RUN;
            ser_row_q <= row_q;
            ser_col_q <= '0;
          end
        end
        SER_RUN: begin
          if (flag_q[ser_idx]) begin
            push_q               <= 1'b1;
            push_dat_q[REL]      <= ~stable[ser_idx];
            push_dat_q[REL-1:0]  <= ser_idx;
          end
          if (ser_col_q == CW'(COLS - 1)) ser_q <= SER_IDLE;
          else ser_col_q <= ser_col_q + CW'(1);
        end
        default: ser_q <= SER_IDLE;
      endcase
    end
  end

  assign ev_valid = (count_q != '0);
  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop      = ev_valid && ev_ready;
  assign wr_en    = push_q && (!full || pop);
  assign drop     = push_q && full && !pop;
  assign ev_data  = ev_valid ? mem_q[rd_ptr_q] : '0;

  // When full with a simultaneous pop, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_dat_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !pop) count_q <= count_q + (AW+1)'(1);
      else if (!wr_en && pop) count_q <= count_q - (AW+1)'(1);
      if (drop) overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end

  assign rowwrite    = rowwrite_q;
  assign pressed_map = stable;
  assign any_pressed = |stable;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed and randomized bench for keypad_scan_ctrl using a frame-level key model.
// Expected events come from the debounce rule applied once per key per frame.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 8, DEBOUNCE = 3, FIFO_DEPTH = 4;
  localparam int NK = ROWS * COLS;
  localparam int FRAME = ROWS * SCAN_DIV;
  localparam int LAT_MAX = (DEBOUNCE + 1) * FRAME + COLS + 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [ROWS-1:0] rowwrite;
  logic [COLS-1:0] colread;
  logic [4:0]      ev_data;
  logic            ev_valid;
  logic            ev_ready;
  logic [NK-1:0]   pressed_map;
  logic            any_pressed;
  logic            overflow;
  logic            ovf_clr;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rowwrite(rowwrite), .colread(colread),
    .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .pressed_map(pressed_map), .any_pressed(any_pressed),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pop = 0;
  int          cyc = 0;
  int          first_valid = -1;
  int          mark, p0;
  logic        rand_ready = 1'b0;
  logic [NK-1:0] keys;
  logic [NK-1:0] m_stable;
  int          m_cnt [NK];
  logic [4:0]  exp_q [$];
  logic [4:0]  pop_dat [$];
  int          pop_cyc [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Physical keypad: a held key on the strobed row pulls its column low.
  function automatic logic [COLS-1:0] col_of(input logic [NK-1:0] k, input logic [ROWS-1:0] rw);
    logic [COLS-1:0] c;
    c = '1;
    for (int r = 0; r < ROWS; r++)
      if (!rw[r])
        for (int cc = 0; cc < COLS; cc++)
          if (k[r*COLS+cc]) c[cc] = 1'b0;
    return c;
  endfunction

  task automatic model_frame();
    for (int k = 0; k < NK; k++) begin
      if (keys[k] == m_stable[k]) begin
        m_cnt[k] = 0;
      end else if (m_cnt[k] == DEBOUNCE - 1) begin
        m_stable[k] = keys[k];
        m_cnt[k] = 0;
        exp_q.push_back({~keys[k], 4'(k)});
      end else begin
        m_cnt[k]++;
      end
    end
  endtask

  task automatic step();
    if (ev_valid && ev_ready) begin
      n_pop++;
      pop_dat.push_back(ev_data);
      pop_cyc.push_back(cyc);
      check("ev_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("ev_data", ev_data, exp_q.pop_front());
    end
    @(posedge clk); #1;
    cyc++;
    colread = col_of(keys, rowwrite);
    if (rand_ready) ev_ready = (cyc % 2 == 0) || ($urandom_range(0, 1) == 1);
    if (ev_valid && first_valid < 0) first_valid = cyc;
  endtask

  task automatic frame_check();
    check("pressed_map", pressed_map, m_stable);
    check("any_pressed", any_pressed, |m_stable);
  endtask

  task automatic run_frames(input int n);
    repeat (n) begin
      colread = col_of(keys, rowwrite);
      model_frame();
      repeat (FRAME) step();
      frame_check();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_stable = '0;
    for (int k = 0; k < NK; k++) m_cnt[k] = 0;
    exp_q.delete();
    colread = col_of(keys, rowwrite);
  endtask

  initial begin
    rst = 1'b1; colread = '1; ev_ready = 1'b1; ovf_clr = 1'b0; keys = '0;
    do_reset();
    check("rst_rowwrite", rowwrite, 4'b1110);
    check("rst_ev_valid", ev_valid, 1'b0);
    check("rst_ev_data", ev_data, 5'd0);
    check("rst_map", pressed_map, 16'd0);
    check("rst_any", any_pressed, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    model_frame();
    repeat (SCAN_DIV - 1) step();
    check("row0_hold", rowwrite, 4'b1110);
    step();
    check("row1_after_tick", rowwrite, 4'b1101);
    repeat (FRAME - SCAN_DIV) step();
    frame_check();

    // Single press and release of key 6 (row 1, column 2).
    p0 = n_pop; pop_dat.delete();
    keys[6] = 1'b1; run_frames(6);
    keys[6] = 1'b0; run_frames(6);
    check("single_evcnt", n_pop - p0, 2);
    if (pop_dat.size() == 2) begin
      check("single_press", pop_dat[0], 5'b0_0110);
      check("single_release", pop_dat[1], 5'b1_0110);
    end
    $display("key 6 legend %h", HEX_MAP_4X4[6]);

    // Bounce shorter than the debounce window.
    p0 = n_pop;
    keys[6] = 1'b1; run_frames(2);
    keys[6] = 1'b0; run_frames(2);
    check("bounce_evcnt", n_pop - p0, 0);

    // Two keys on row 2 mature on the same tick.
    pop_dat.delete(); pop_cyc.delete();
    keys[8] = 1'b1; keys[11] = 1'b1; run_frames(4);
    check("pair_evcnt", pop_dat.size(), 2);
    if (pop_dat.size() == 2) begin
      check("pair_first", pop_dat[0], 5'b0_1000);
      check("pair_second", pop_dat[1], 5'b0_1011);
      check("pair_same_tick", (pop_cyc[1] - pop_cyc[0] >= 1) && (pop_cyc[1] - pop_cyc[0] <= COLS), 1'b1);
    end
    keys = '0; run_frames(4);

    // Randomized key activity with throttled consumer.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 1) == 1) keys[$urandom_range(0, NK - 1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, NK - 1)] ^= 1'b1;
      run_frames(1);
    end
    rand_ready = 1'b0; ev_ready = 1'b1;
    keys = '0; run_frames(5);
    check("rand_drained", exp_q.size(), 0);
    check("rand_no_ovf", overflow, 1'b0);

    // Overflow: six events into a four-entry FIFO with no consumer.
    ev_ready = 1'b0;
    keys[0] = 1'b1; keys[1] = 1'b1; keys[2] = 1'b1; run_frames(4);
    keys = '0; run_frames(4);
    check("ovf_model_events", exp_q.size(), 6);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_valid", ev_valid, 1'b1);
    while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
    colread = col_of(keys, rowwrite);
    model_frame();
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 1'b0);
    ev_ready = 1'b1;
    repeat (FRAME - 1) step();
    frame_check();
    check("ovf_popped_all", exp_q.size(), 0);
    check("ovf_empty", ev_valid, 1'b0);

    // Reset in the serializer cycle right after key 6's flipping tick.
    keys[6] = 1'b1; run_frames(2);
    repeat (2 * SCAN_DIV) step();
    check("midrst_map6_pre", pressed_map[6], 1'b1);
    check("midrst_valid_pre", ev_valid, 1'b0);
    do_reset();
    check("midrst_valid", ev_valid, 1'b0);
    check("midrst_map", pressed_map, 16'd0);
    repeat (6) step();
    check("midrst_no_stale", ev_valid, 1'b0);
    do_reset();
    p0 = n_pop; mark = cyc; first_valid = -1; pop_dat.delete();
    run_frames(4);
    check("midrst_evcnt", n_pop - p0, 1);
    if (pop_dat.size() == 1) check("midrst_press", pop_dat[0], 5'b0_0110);
    check("press_latency", (first_valid >= 0) && (first_valid - mark <= LAT_MAX), 1'b1);
    check("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
